// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg.sv -- state/field codes, BCD time layout and wrap limits
// shared by the SSD timer controller files.
package timer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PAUSE,
    ST_SET_DAY,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC
  } state_e;

  localparam logic [1:0] FIELD_DAY  = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef struct packed {
    logic [3:0] day;
    logic [1:0] hr_h;
    logic [3:0] hr_l;
    logic [2:0] mn_h;
    logic [3:0] mn_l;
    logic [2:0] sc_h;
    logic [3:0] sc_l;
  } bcd_time_t;

  localparam int unsigned BCD_W = $bits(bcd_time_t);

  localparam logic [3:0] DAY_MAX   = 4'd9;
  localparam logic [1:0] HR_MAX_H  = 2'd2;
  localparam logic [3:0] HR_MAX_L  = 4'd3;
  localparam logic [2:0] MS_MAX_H  = 3'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  function automatic logic [6:0] ms_inc(
    logic [2:0] h,
    logic [3:0] l
  );
    if (l < DIGIT_MAX) return {h, l + 4'd1};
    if (h >= MS_MAX_H) return '0;
    return {h + 3'd1, 4'd0};
  endfunction

  function automatic bcd_time_t bcd_inc(
    bcd_time_t  t,
    logic [1:0] f
  );
    bcd_time_t r;
    r = t;
    case (f)
      FIELD_DAY: begin
        r.day = (t.day >= DAY_MAX) ? 4'd0 : t.day + 4'd1;
      end
      FIELD_HOUR: begin
        if (t.hr_h == HR_MAX_H && t.hr_l >= HR_MAX_L) begin
          r.hr_h = '0;
          r.hr_l = '0;
        end else if (t.hr_l >= DIGIT_MAX) begin
          r.hr_h = t.hr_h + 2'd1;
          r.hr_l = '0;
        end else begin
          r.hr_l = t.hr_l + 4'd1;
        end
      end
      FIELD_MIN: begin
        {r.mn_h, r.mn_l} = ms_inc(t.mn_h, t.mn_l);
      end
      default: begin
        {r.sc_h, r.sc_l} = ms_inc(t.sc_h, t.sc_l);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge.sv -- two-flop synchroniser plus rising-edge detect
// for an asynchronous, already-debounced button level.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic rise_o
);

  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], pin_i};
  end

  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl.sv -- run/pause/set controller for the day/hh:mm:ss SSD timer.
// Define TIMER_CTRL_BLINK_EN to add the set-mode digit blink generator.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_run,
  input  logic [23:0] cur_bcd,
  output logic        tick_en,
  output logic        load,
  output logic [23:0] load_bcd,
  output logic        set_mode,
  output logic [1:0]  field_sel,
  output logic [6:0]  blink_mask
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // reset asserts immediately, releases two clocks later
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ni = rst_sync_q[1];

  logic mode_re, inc_re, run_re;

  btn_sync_edge u_mode (
    .clk    (clk),
    .rst_n  (rst_ni),
    .pin_i  (btn_mode),
    .rise_o (mode_re)
  );

  btn_sync_edge u_inc (
    .clk    (clk),
    .rst_n  (rst_ni),
    .pin_i  (btn_inc),
    .rise_o (inc_re)
  );

  btn_sync_edge u_run (
    .clk    (clk),
    .rst_n  (rst_ni),
    .pin_i  (btn_run),
    .rise_o (run_re)
  );

  state_e           state_q, state_d;
  bcd_time_t        edit_q, edit_d;
  logic             load_q, load_d;
  logic [BCD_W-1:0] load_bcd_q, load_bcd_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RUN;
      edit_q     <= '0;
      load_q     <= 1'b0;
      load_bcd_q <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      load_q     <= load_d;
      load_bcd_q <= load_bcd_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    set_mode  = 1'b1;
    field_sel = FIELD_DAY;
    unique case (state_q)
      ST_SET_DAY:  field_sel = FIELD_DAY;
      ST_SET_HOUR: field_sel = FIELD_HOUR;
      ST_SET_MIN:  field_sel = FIELD_MIN;
      ST_SET_SEC:  field_sel = FIELD_SEC;
      default:     set_mode  = 1'b0;
    endcase
  end

  // mode wins over inc/run; losing edges are simply dropped
  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    load_d     = 1'b0;
    load_bcd_d = load_bcd_q;
    if (!set_mode) begin
      if (mode_re) begin
        state_d = ST_SET_DAY;
        edit_d  = bcd_time_t'(cur_bcd);
      end else if (run_re) begin
        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
    end else if (mode_re) begin
      unique case (state_q)
        ST_SET_DAY:  state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_SET_SEC;
        default: begin
          state_d    = ST_RUN;
          load_d     = 1'b1;
          load_bcd_d = edit_q;
        end
      endcase
    end else if (inc_re) begin
      edit_d = bcd_inc(edit_q, field_sel);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (state_q == ST_RUN) begin
      tick_d = (cnt_q == DIV_LAST);
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end else if (set_mode) begin
      cnt_d = '0;
    end
  end

  assign tick_en  = tick_q;
  assign load     = load_q;
  assign load_bcd = load_bcd_q;

`ifdef TIMER_CTRL_BLINK_EN
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned BL_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic            phase_q, phase_d;
  logic            enter_set;

  assign enter_set = mode_re & ~set_mode;

  always_comb begin
    bl_cnt_d = bl_cnt_q;
    phase_d  = phase_q;
    if (enter_set) begin
      bl_cnt_d = '0;
      phase_d  = 1'b0;
    end else if (set_mode) begin
      if (bl_cnt_q == BL_W'(HALF - 1)) begin
        bl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      bl_cnt_q <= '0;
      phase_q  <= 1'b0;
    end else begin
      bl_cnt_q <= bl_cnt_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    blink_mask = '0;
    if (set_mode) begin
      unique case (field_sel)
        FIELD_DAY:  blink_mask[6]   = phase_q;
        FIELD_HOUR: blink_mask[5:4] = {2{phase_q}};
        FIELD_MIN:  blink_mask[3:2] = {2{phase_q}};
        default:    blink_mask[1:0] = {2{phase_q}};
      endcase
    end
  end
`else
  assign blink_mask = '0;
`endif

endmodule
